tx_ptp_sched: RTL and testbench
===============================

# tx_ptp_sched

Round-robin scheduler and bus-master sequencer that shares the single PTP transmit frame buffer among N frame requesters (Sync, Delay_Req, Announce, etc.). It grants one requester at a time and copies that requester's frame words into the buffer over the 32-bit on-chip bus. It then writes frame length and the tx_start bit, waits for tx_start to self-clear, and holds the buffer for a guard interval so the XGMII side can finish reading. It sits between the PTP message generators and the transmit frame buffer, all in the bus2ip_clk domain.

## Interface
- N, 4: number of requesters (2..8).
- TX_BUF_BADDR, 32'h2000: buffer base address. Control register is at TX_BUF_BADDR+32'h200.
- GUARD_CYCLES, 80: bus2ip_clk cycles the buffer is held after tx_start clears. Sized for a 511-byte frame with tx_clk ≥ bus2ip_clk.
- POLL_MAX, 16: maximum poll cycles before a timeout error.
- bus2ip_clk  in  1  clock.
- bus2ip_rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  N  per-requester frame request; held high until that requester's done_o.
- len_i  in  N*9  per-requester frame length in bytes; slice i is [9i+8:9i].
- grant_o  out  N  one-hot grant.
- word_req_o  out  1  word fetch strobe to the granted requester.
- word_idx_o  out  7  word index being fetched.
- word_data_i  in  N*32  per-requester word; valid the cycle after word_req_o.
- done_o  out  N  one-cycle completion pulse to the granted requester.
- err_o  out  1  one-cycle pulse, coincident with done_o, for a rejected or timed-out frame.
- busy_o  out  1  high in any state other than IDLE.
- m_addr_o  out  32  bus master address.
- m_data_o  out  32  bus master write data.
- m_wr_ce_o  out  1  bus write strobe, active high.
- m_rd_ce_o  out  1  bus read strobe, active high.
- m_data_i  in  32  bus read data; combinational in the same cycle as m_rd_ce_o.

## Operation
- States:
  - IDLE
  - FETCH
  - WRITE
  - CTRL
  - POLL
  - GUARD
  - DONE
- IDLE:
  - If |req_i, the round-robin pick is registered into grant_o. Search starts at index ptr (ptr = last served + 1 mod N).
  - len_i of the winner is latched into len_r. W = (len_r+3)>>2, using a 10-bit intermediate.
  - Next state is FETCH with k=0. If len_r==0, next state is DONE with err flagged.
- FETCH: word_req_o=1, word_idx_o=k. Next state is WRITE.
- WRITE:
  - m_wr_ce_o=1, m_addr_o=TX_BUF_BADDR+4k, m_data_o = the granted slice of word_data_i.
  - If k==W-1, next state is CTRL; otherwise k++ and next state is FETCH.
- CTRL: m_wr_ce_o=1, m_addr_o=TX_BUF_BADDR+32'h200, m_data_o={16'b0,1'b1,6'b0,len_r}. Next state is POLL.
- POLL:
  - m_rd_ce_o=1 with the control address.
  - If m_data_i[15]==0, next state is GUARD.
  - Otherwise the poll counter increments. When it reaches POLL_MAX, err is flagged and next state is GUARD.
- GUARD: counts GUARD_CYCLES cycles, then next state is DONE.
- DONE:
  - done_o = grant_o for one cycle; err_o = err flag.
  - ptr = granted index + 1 mod N; grant_o cleared; err cleared.
  - Next state is IDLE.
- Boundary conditions:
  - Deasserting req_i mid-frame is ignored; the frame completes.
  - len_i changes after latch are ignored.
  - len_r=511 gives W=128 with word indices 0..127. There is no wrap past 127.
  - Simultaneous requests are served strictly round-robin. A requester re-asserting in IDLE right after its own DONE waits behind the other pending requesters.
- Reset mid-operation: returns to IDLE; ptr=0, counters cleared. The buffer shares this reset, so a partially loaded frame is discarded.

## Timing
- Reset values: all outputs 0. ptr=0, k=0.
- grant_o rises the cycle after req_i is seen in IDLE. It stays high through DONE inclusive.
- word_req_o and m_wr_ce_o alternate, 2 cycles per word. Bus strobes are single-cycle and never assert together.
- done_o occurs at grant rise + 2W + 1 + P + GUARD_CYCLES cycles, where P = number of POLL cycles including the exiting one (nominally 3).
- For len_r==0, done_o and err_o occur the cycle after grant rise.
- After DONE, the earliest next grant is 1 cycle later (IDLE evaluation).

## Structure
- Package ptp_sched_pkg holds:
  - the state enum;
  - the control offset 32'h200;
  - the tx_start bit position 15;
  - the frame length width 9;
  - the buffer word depth 128.
- One sub-module, ptp_rr_arb: N-way round-robin priority pick from req and ptr. It is combinational plus the ptr register.

## Test plan
- Single requester 0, len=64 → 16 writes to 0x2000..0x203C with data in order. CTRL data 0x0000_8040. done_o[0] at grant+33+P+80. err_o=0.
- len=61 → W=16. Last write addr 0x203C. CTRL data 0x0000_803D.
- req_i=4'b1010 asserted together, ptr=0 → requester 1 served, then 3. Then requester 1 re-asserts together with 0 → 0 is served before 1.
- len=0 on requester 2 → no bus strobes. done_o[2] and err_o pulse at grant+1.
- Hold m_data_i[15]=1 → err_o asserted with done_o after 16 POLL cycles plus GUARD_CYCLES.
- Assert bus2ip_rst_n low during WRITE of word 5 → all outputs 0 immediately. After release the bench re-requests, and the request is served from word 0 with ptr=0.

Source files
------------

// File: rtl/tx_ptp_sched_pkg.sv
// Shared types and constants for the PTP transmit-buffer scheduler.
package ptp_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WRITE = 3'd2,
      ST_CTRL  = 3'd3,
      ST_POLL  = 3'd4,
      ST_GUARD = 3'd5,
      ST_DONE  = 3'd6
   } sched_state_e;

   localparam logic [31:0] CTRL_OFFSET  = 32'h200;
   localparam int unsigned TX_START_BIT = 15;
   localparam int unsigned LEN_W        = 9;
   localparam int unsigned BUF_WORDS    = 128;
   localparam int unsigned WIDX_W       = $clog2(BUF_WORDS);

   // Layout of the buffer control register
   typedef struct packed {
      logic [15:0]      rsvd_hi;
      logic             tx_start;
      logic [5:0]       rsvd_lo;
      logic [LEN_W-1:0] len;
   } tx_ctrl_t;

   function automatic tx_ctrl_t make_ctrl(input logic [LEN_W-1:0] len);
      tx_ctrl_t c;
      c          = '0;
      c.tx_start = 1'b1;
      c.len      = len;
      return c;
   endfunction

endpackage

// File: rtl/tx_ptp_sched_rr_arb.sv
// N-way round-robin pick; search starts at ptr, ptr advances past each served requester.
module ptp_rr_arb
   import ptp_sched_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic          bus2ip_clk,
   input  logic          bus2ip_rst_n,
   input  logic [N-1:0]  req,
   input  logic          upd,
   input  logic [IW-1:0] upd_idx,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] pick_idx,
   output logic          pick_vld
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] j;

   always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
      if (!bus2ip_rst_n) begin
         ptr_q <= '0;
      end else if (upd) begin
         ptr_q <= (upd_idx == IW'(N-1)) ? '0 : upd_idx + IW'(1);
      end
   end

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      j        = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = IW'((32'(ptr_q) + i) % N);
         if (!pick_vld && req[j]) begin
            pick_vld = 1'b1;
            pick_idx = j;
            pick[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_ptp_sched.sv
// Shares the PTP transmit frame buffer among N requesters: copies the granted frame,
// kicks tx_start, waits for it to clear, then holds the buffer for a guard interval.
module tx_ptp_sched
   import ptp_sched_pkg::*;
#(
   parameter int unsigned N            = 4,
   parameter logic [31:0] TX_BUF_BADDR = 32'h2000,
   parameter int unsigned GUARD_CYCLES = 80,
   parameter int unsigned POLL_MAX     = 16
) (
   input  logic               bus2ip_clk,
   input  logic               bus2ip_rst_n,
   input  logic [N-1:0]       req_i,
   input  logic [N*LEN_W-1:0] len_i,
   output logic [N-1:0]       grant_o,
   output logic               word_req_o,
   output logic [WIDX_W-1:0]  word_idx_o,
   input  logic [N*32-1:0]    word_data_i,
   output logic [N-1:0]       done_o,
   output logic               err_o,
   output logic               busy_o,
   output logic [31:0]        m_addr_o,
   output logic [31:0]        m_data_o,
   output logic               m_wr_ce_o,
   output logic               m_rd_ce_o,
   input  logic [31:0]        m_data_i
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW = $clog2(POLL_MAX + 1);
   localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [31:0] CTRL_ADDR = TX_BUF_BADDR + CTRL_OFFSET;

   sched_state_e      state_q, state_d;
   logic [WIDX_W-1:0] k_q, k_d;
   logic [PW-1:0]     poll_q, poll_d;
   logic [GW-1:0]     guard_q, guard_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              err_q, err_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic [N-1:0]      grant_d;

   logic [N-1:0]      arb_pick;
   logic [IW-1:0]     arb_idx;
   logic              arb_vld;

   logic [N-1:0]      grant_nx, done_nx;
   logic              word_req_nx, err_nx, busy_nx, m_wr_nx, m_rd_nx;
   logic [WIDX_W-1:0] word_idx_nx;
   logic [31:0]       m_addr_nx;

   logic [LEN_W-1:0]  len_sel  [N];
   logic [31:0]       word_sel [N];
   logic [9:0]        wcnt;
   logic [WIDX_W-1:0] wlast;
   tx_ctrl_t          ctrl_word;
   logic              unused_rd;

   for (genvar i = 0; i < N; i++) begin : g_slice
      assign len_sel[i]  = len_i[LEN_W*i +: LEN_W];
      assign word_sel[i] = word_data_i[32*i +: 32];
   end

   // Word count rounds the byte length up; 10 bits so 511+3 does not overflow
   assign wcnt      = (10'(len_q) + 10'd3) >> 2;
   assign wlast     = WIDX_W'(wcnt - 10'd1);
   assign ctrl_word = make_ctrl(len_q);
   assign unused_rd = ^{m_data_i[31:TX_START_BIT+1], m_data_i[TX_START_BIT-1:0]};

   ptp_rr_arb #(.N(N), .IW(IW)) u_arb (
      .bus2ip_clk   (bus2ip_clk),
      .bus2ip_rst_n (bus2ip_rst_n),
      .req          (req_i),
      .upd          (state_q == ST_DONE),
      .upd_idx      (gidx_q),
      .pick         (arb_pick),
      .pick_idx     (arb_idx),
      .pick_vld     (arb_vld)
   );

   // State, counters and registered outputs
   always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
      if (!bus2ip_rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         poll_q     <= '0;
         guard_q    <= '0;
         len_q      <= '0;
         err_q      <= 1'b0;
         gidx_q     <= '0;
         grant_o    <= '0;
         word_req_o <= 1'b0;
         word_idx_o <= '0;
         done_o     <= '0;
         err_o      <= 1'b0;
         busy_o     <= 1'b0;
         m_addr_o   <= '0;
         m_wr_ce_o  <= 1'b0;
         m_rd_ce_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         poll_q     <= poll_d;
         guard_q    <= guard_d;
         len_q      <= len_d;
         err_q      <= err_d;
         gidx_q     <= gidx_d;
         grant_o    <= grant_nx;
         word_req_o <= word_req_nx;
         word_idx_o <= word_idx_nx;
         done_o     <= done_nx;
         err_o      <= err_nx;
         busy_o     <= busy_nx;
         m_addr_o   <= m_addr_nx;
         m_wr_ce_o  <= m_wr_nx;
         m_rd_ce_o  <= m_rd_nx;
      end
   end

   // Next state; zero length is rejected from FETCH once len_q is valid
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      poll_d  = poll_q;
      guard_d = guard_q;
      len_d   = len_q;
      err_d   = err_q;
      gidx_d  = gidx_q;
      grant_d = grant_o;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               grant_d = arb_pick;
               gidx_d  = arb_idx;
               len_d   = len_sel[arb_idx];
               k_d     = '0;
               poll_d  = '0;
               guard_d = '0;
               err_d   = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (len_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (k_q == wlast) begin
               state_d = ST_CTRL;
            end else begin
               k_d     = k_q + WIDX_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_CTRL: begin
            poll_d  = '0;
            state_d = ST_POLL;
         end
         ST_POLL: begin
            if (!m_data_i[TX_START_BIT]) begin
               guard_d = '0;
               state_d = ST_GUARD;
            end else if (poll_q == PW'(POLL_MAX - 1)) begin
               err_d   = 1'b1;
               guard_d = '0;
               state_d = ST_GUARD;
            end else begin
               poll_d = poll_q + PW'(1);
            end
         end
         ST_GUARD: begin
            if (guard_q == GW'(GUARD_CYCLES - 1)) begin
               state_d = ST_DONE;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         ST_DONE: begin
            grant_d = '0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up with it
   always_comb begin
      grant_nx    = grant_d;
      busy_nx     = (state_d != ST_IDLE);
      word_req_nx = (state_d == ST_FETCH) && (len_d != '0);
      word_idx_nx = (state_d == ST_FETCH) ? k_d : '0;
      m_wr_nx     = (state_d == ST_WRITE) || (state_d == ST_CTRL);
      m_rd_nx     = (state_d == ST_POLL);
      done_nx     = (state_d == ST_DONE) ? grant_d : '0;
      err_nx      = (state_d == ST_DONE) && err_d;
      m_addr_nx   = '0;
      case (state_d)
         ST_WRITE:         m_addr_nx = TX_BUF_BADDR + 32'({k_d, 2'b00});
         ST_CTRL, ST_POLL: m_addr_nx = CTRL_ADDR;
         default:          m_addr_nx = '0;
      endcase
   end

   // Write data passes straight through: requester data is valid only in the WRITE cycle
   always_comb begin
      m_data_o = '0;
      case (state_q)
         ST_WRITE: m_data_o = word_sel[gidx_q];
         ST_CTRL:  m_data_o = ctrl_word;
         default:  m_data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_tx_ptp_sched.sv
// Directed bench for tx_ptp_sched: requester/buffer models plus per-scenario checks.
module tb_tx_ptp_sched;

   localparam int unsigned N = 4;
   localparam int unsigned G = 80;

   logic            bus2ip_clk = 1'b0;
   logic            bus2ip_rst_n = 1'b0;
   logic [N-1:0]    req_i = '0;
   logic [N*9-1:0]  len_i = '0;
   logic [N-1:0]    grant_o;
   logic            word_req_o;
   logic [6:0]      word_idx_o;
   logic [N*32-1:0] word_data_i;
   logic [N-1:0]    done_o;
   logic            err_o, busy_o;
   logic [31:0]     m_addr_o, m_data_o, m_data_i;
   logic            m_wr_ce_o, m_rd_ce_o;

   tx_ptp_sched #(.N(N), .TX_BUF_BADDR(32'h2000), .GUARD_CYCLES(G), .POLL_MAX(16)) dut (
      .bus2ip_clk(bus2ip_clk), .bus2ip_rst_n(bus2ip_rst_n), .req_i(req_i), .len_i(len_i),
      .grant_o(grant_o), .word_req_o(word_req_o), .word_idx_o(word_idx_o),
      .word_data_i(word_data_i), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_wr_ce_o(m_wr_ce_o),
      .m_rd_ce_o(m_rd_ce_o), .m_data_i(m_data_i)
   );

   always #5 bus2ip_clk = ~bus2ip_clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge bus2ip_clk) cyc <= cyc + 1;

   // Requester model: word returned the cycle after the fetch strobe
   logic [6:0] last_idx = '0;
   always @(posedge bus2ip_clk) if (word_req_o) last_idx <= word_idx_o;
   for (genvar r = 0; r < N; r++) begin : g_req
      assign word_data_i[32*r +: 32] = {8'(8'hA0 + r), 8'h5C, 9'd0, last_idx};
   end

   // Buffer model: tx_start reads back set for poll_hold reads after the control write
   int poll_hold = 2;
   int poll_seen = 0;
   always @(posedge bus2ip_clk) begin
      if (m_wr_ce_o && m_addr_o == 32'h2200) poll_seen <= 0;
      else if (m_rd_ce_o) poll_seen <= poll_seen + 1;
   end
   assign m_data_i = {16'h0, (poll_seen < poll_hold), 15'h0};

   // Bus / handshake monitor
   logic [31:0]  wr_addr [1024];
   logic [31:0]  wr_data [1024];
   int           wr_cnt = 0, rd_cnt = 0, wreq_cnt = 0, clash_cnt = 0, stray_err = 0;
   int           grant_cyc = 0, done_cyc = 0, done_cnt = 0;
   logic [N-1:0] done_val = '0, prev_grant = '0;
   logic         done_err = 1'b0;
   always @(negedge bus2ip_clk) begin
      if (m_wr_ce_o) begin
         wr_addr[wr_cnt % 1024] <= m_addr_o;
         wr_data[wr_cnt % 1024] <= m_data_o;
         wr_cnt <= wr_cnt + 1;
      end
      if (m_rd_ce_o) rd_cnt <= rd_cnt + 1;
      if (word_req_o) wreq_cnt <= wreq_cnt + 1;
      if ((m_wr_ce_o && (m_rd_ce_o || word_req_o)) || (m_rd_ce_o && word_req_o))
         clash_cnt <= clash_cnt + 1;
      if (err_o && done_o == '0) stray_err <= stray_err + 1;
      if (grant_o != '0 && prev_grant == '0) grant_cyc <= cyc;
      prev_grant <= grant_o;
      if (done_o != '0) begin
         done_cyc <= cyc;
         done_val <= done_o;
         done_err <= err_o;
         done_cnt <= done_cnt + 1;
      end
   end

   task automatic step();
      @(negedge bus2ip_clk);
      #1;
   endtask

   task automatic wait_done(output logic ok);
      int base;
      base = done_cnt;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         step();
         if (done_cnt != base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      step(); step();
      tests++; if ({grant_o, word_req_o, word_idx_o, done_o, err_o, busy_o, m_wr_ce_o, m_rd_ce_o} !== 20'h0) begin
         fails++; $display("FAIL reset_ctrl: got %h expected 0", {grant_o, word_req_o, word_idx_o, done_o, err_o, busy_o, m_wr_ce_o, m_rd_ce_o}); end
      tests++; if ({m_addr_o, m_data_o} !== 64'h0) begin
         fails++; $display("FAIL reset_bus: got %h expected 0", {m_addr_o, m_data_o}); end
      bus2ip_rst_n = 1'b1;
      step(); step();
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_single_len64();
      int bw, brd, bwq, drv;
      logic ok;
      bw = wr_cnt; brd = rd_cnt; bwq = wreq_cnt; drv = cyc;
      len_i[8:0] = 9'd64;
      req_i = 4'b0001;
      wait_done(ok);
      req_i = '0;
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL len64_timeout: got %b expected 1", ok); end
      tests++; if (done_val !== 4'b0001) begin fails++; $display("FAIL len64_done: got %b expected 0001", done_val); end
      tests++; if (done_err !== 1'b0) begin fails++; $display("FAIL len64_err: got %b expected 0", done_err); end
      tests++; if (grant_cyc - drv != 1) begin fails++; $display("FAIL len64_grant_lat: got %0d expected 1", grant_cyc - drv); end
      tests++; if (done_cyc - grant_cyc != 116) begin fails++; $display("FAIL len64_done_lat: got %0d expected 116", done_cyc - grant_cyc); end
      tests++; if (wr_cnt - bw != 17) begin fails++; $display("FAIL len64_nwr: got %0d expected 17", wr_cnt - bw); end
      tests++; if (wreq_cnt - bwq != 16) begin fails++; $display("FAIL len64_nfetch: got %0d expected 16", wreq_cnt - bwq); end
      tests++; if (rd_cnt - brd != 3) begin fails++; $display("FAIL len64_npoll: got %0d expected 3", rd_cnt - brd); end
      for (int k = 0; k < 16; k++) begin
         logic [63:0] exp_w;
         exp_w = {32'h2000 + 32'(4*k), 8'hA0, 8'h5C, 9'd0, 7'(k)};
         tests++; if ({wr_addr[(bw+k)%1024], wr_data[(bw+k)%1024]} !== exp_w) begin
            fails++; $display("FAIL len64_word%0d: got %h expected %h", k, {wr_addr[(bw+k)%1024], wr_data[(bw+k)%1024]}, exp_w); end
      end
      tests++; if ({wr_addr[(bw+16)%1024], wr_data[(bw+16)%1024]} !== {32'h2200, 32'h0000_8040}) begin
         fails++; $display("FAIL len64_ctrl: got %h expected 0000220000008040", {wr_addr[(bw+16)%1024], wr_data[(bw+16)%1024]}); end
   endtask

   task automatic test_len61_ignore_changes();
      int bw;
      logic ok;
      bw = wr_cnt;
      len_i[35:27] = 9'd61;
      req_i = 4'b1000;
      step(); step();
      len_i[35:27] = 9'd200;
      step(); step(); step();
      req_i = '0;
      wait_done(ok);
      tests++; if (ok !== 1'b1 || done_val !== 4'b1000) begin fails++; $display("FAIL len61_done: got %b expected 1000", done_val); end
      tests++; if (done_cyc - grant_cyc != 116) begin fails++; $display("FAIL len61_done_lat: got %0d expected 116", done_cyc - grant_cyc); end
      tests++; if (wr_cnt - bw != 17) begin fails++; $display("FAIL len61_nwr: got %0d expected 17", wr_cnt - bw); end
      tests++; if ({wr_addr[(bw+15)%1024], wr_data[(bw+15)%1024]} !== {32'h203C, 32'hA35C_000F}) begin
         fails++; $display("FAIL len61_last: got %h expected 0000203CA35C000F", {wr_addr[(bw+15)%1024], wr_data[(bw+15)%1024]}); end
      tests++; if (wr_data[(bw+16)%1024] !== 32'h0000_803D) begin
         fails++; $display("FAIL len61_ctrl: got %h expected 0000803D", wr_data[(bw+16)%1024]); end
   endtask

   task automatic test_round_robin();
      logic ok1, ok2, ok3, ok4;
      logic [N-1:0] d1, d3;
      int g1, dc1;
      len_i[17:9] = 9'd8;
      len_i[35:27] = 9'd4;
      req_i = 4'b1010;
      wait_done(ok1);
      d1 = done_val; g1 = grant_cyc; dc1 = done_cyc;
      req_i[1] = 1'b0;
      wait_done(ok2);
      req_i[3] = 1'b0;
      tests++; if (!(ok1 && ok2)) begin fails++; $display("FAIL rr_timeout: got %b%b expected 11", ok1, ok2); end
      tests++; if (d1 !== 4'b0010) begin fails++; $display("FAIL rr_first: got %b expected 0010", d1); end
      tests++; if (dc1 - g1 != 88) begin fails++; $display("FAIL rr_first_lat: got %0d expected 88", dc1 - g1); end
      tests++; if (done_val !== 4'b1000) begin fails++; $display("FAIL rr_second: got %b expected 1000", done_val); end
      tests++; if (grant_cyc - dc1 != 2) begin fails++; $display("FAIL rr_regrant_gap: got %0d expected 2", grant_cyc - dc1); end
      tests++; if (done_cyc - grant_cyc != 86) begin fails++; $display("FAIL rr_second_lat: got %0d expected 86", done_cyc - grant_cyc); end
      len_i[8:0] = 9'd4;
      len_i[17:9] = 9'd4;
      req_i = 4'b0011;
      wait_done(ok3);
      d3 = done_val;
      req_i[0] = 1'b0;
      wait_done(ok4);
      req_i = '0;
      tests++; if (!(ok3 && ok4) || d3 !== 4'b0001) begin fails++; $display("FAIL rr_wrap_first: got %b expected 0001", d3); end
      tests++; if (done_val !== 4'b0010) begin fails++; $display("FAIL rr_wrap_second: got %b expected 0010", done_val); end
   endtask

   task automatic test_len_zero();
      int bw, brd, bwq;
      logic ok;
      bw = wr_cnt; brd = rd_cnt; bwq = wreq_cnt;
      len_i[26:18] = 9'd0;
      req_i = 4'b0100;
      wait_done(ok);
      req_i = '0;
      tests++; if (ok !== 1'b1 || done_val !== 4'b0100) begin fails++; $display("FAIL zero_done: got %b expected 0100", done_val); end
      tests++; if (done_err !== 1'b1) begin fails++; $display("FAIL zero_err: got %b expected 1", done_err); end
      tests++; if (done_cyc - grant_cyc != 1) begin fails++; $display("FAIL zero_lat: got %0d expected 1", done_cyc - grant_cyc); end
      tests++; if ((wr_cnt - bw) + (rd_cnt - brd) + (wreq_cnt - bwq) != 0) begin
         fails++; $display("FAIL zero_strobes: got %0d expected 0", (wr_cnt - bw) + (rd_cnt - brd) + (wreq_cnt - bwq)); end
   endtask

   task automatic test_poll_timeout();
      int brd;
      logic ok;
      brd = rd_cnt;
      poll_hold = 1000;
      len_i[26:18] = 9'd4;
      req_i = 4'b0100;
      wait_done(ok);
      req_i = '0;
      poll_hold = 2;
      tests++; if (ok !== 1'b1 || done_val !== 4'b0100) begin fails++; $display("FAIL poll_done: got %b expected 0100", done_val); end
      tests++; if (done_err !== 1'b1) begin fails++; $display("FAIL poll_err: got %b expected 1", done_err); end
      tests++; if (rd_cnt - brd != 16) begin fails++; $display("FAIL poll_count: got %0d expected 16", rd_cnt - brd); end
      tests++; if (done_cyc - grant_cyc != 99) begin fails++; $display("FAIL poll_lat: got %0d expected 99", done_cyc - grant_cyc); end
   endtask

   task automatic test_reset_mid_frame();
      logic found, ok1, ok2;
      logic [N-1:0] d1;
      int bw, nw, g1, dc1;
      found = 1'b0;
      len_i[17:9] = 9'd40;
      len_i[35:27] = 9'd4;
      req_i = 4'b0010;
      for (int t = 0; t < 200; t++) begin
         step();
         if (m_wr_ce_o && m_addr_o == 32'h2014) begin
            found = 1'b1;
            break;
         end
      end
      tests++; if (found !== 1'b1) begin fails++; $display("FAIL rst_reach_word5: got %b expected 1", found); end
      bus2ip_rst_n = 1'b0;
      req_i = '0;
      #1;
      tests++; if ({grant_o, word_req_o, word_idx_o, done_o, err_o, busy_o, m_wr_ce_o, m_rd_ce_o} !== 20'h0) begin
         fails++; $display("FAIL rst_mid_ctrl: got %h expected 0", {grant_o, word_req_o, word_idx_o, done_o, err_o, busy_o, m_wr_ce_o, m_rd_ce_o}); end
      tests++; if ({m_addr_o, m_data_o} !== 64'h0) begin
         fails++; $display("FAIL rst_mid_bus: got %h expected 0", {m_addr_o, m_data_o}); end
      step(); step();
      bus2ip_rst_n = 1'b1;
      step();
      bw = wr_cnt;
      req_i = 4'b1010;
      wait_done(ok1);
      d1 = done_val; g1 = grant_cyc; dc1 = done_cyc; nw = wr_cnt - bw;
      req_i[1] = 1'b0;
      wait_done(ok2);
      req_i = '0;
      tests++; if (!(ok1 && ok2) || d1 !== 4'b0010) begin fails++; $display("FAIL rst_ptr_pick: got %b expected 0010", d1); end
      tests++; if ({wr_addr[bw%1024], wr_data[bw%1024]} !== {32'h2000, 32'hA15C_0000}) begin
         fails++; $display("FAIL rst_restart_word0: got %h expected 00002000A15C0000", {wr_addr[bw%1024], wr_data[bw%1024]}); end
      tests++; if (nw != 11) begin fails++; $display("FAIL rst_restart_nwr: got %0d expected 11", nw); end
      tests++; if (dc1 - g1 != 104) begin fails++; $display("FAIL rst_restart_lat: got %0d expected 104", dc1 - g1); end
      tests++; if (done_val !== 4'b1000) begin fails++; $display("FAIL rst_then_next: got %b expected 1000", done_val); end
   endtask

   initial begin
      test_reset();
      test_single_len64();
      test_len61_ignore_changes();
      test_round_robin();
      test_len_zero();
      test_poll_timeout();
      test_reset_mid_frame();
      step();
      tests++; if (clash_cnt != 0) begin fails++; $display("FAIL strobe_overlap: got %0d expected 0", clash_cnt); end
      tests++; if (stray_err != 0) begin fails++; $display("FAIL err_without_done: got %0d expected 0", stray_err); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
